// File: rtl/score_keeper_if.sv
// Point events and score/serve status exchanged between the game logic and score_keeper.
interface score_keeper_if;
  logic       p1_point;
  logic       p2_point;
  logic       new_game;
  logic [7:0] p1_score;
  logic [7:0] p2_score;
  logic       frozen;
  logic       serve;
  logic       serve_side;
  logic [1:0] winner;
  logic       game_over;

  modport master (
    output p1_point, p2_point, new_game,
    input  p1_score, p2_score, frozen, serve, serve_side, winner, game_over
  );

  modport slave (
    input  p1_point, p2_point, new_game,
    output p1_score, p2_score, frozen, serve, serve_side, winner, game_over
  );
endinterface

// File: rtl/score_keeper.sv
// Two-player scoring controller: edge-detected points, saturating scores, timed
// post-point freeze with serve pulse, win-by-two match detection.
module score_keeper #(
  parameter int WIN_SCORE    = 11,
  parameter int PAUSE_CYCLES = 50_000_000,
  parameter int MAX_SCORE    = 99
) (
  input  logic        clk,
  input  logic        resetn,
  score_keeper_if.slave sk
);
  localparam int CW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PAUSE_CYCLES - 1);
  localparam logic [7:0]    MAX_S    = 8'(MAX_SCORE);
  localparam logic [7:0]    WIN_S    = 8'(WIN_SCORE);

  typedef enum logic [1:0] {S_PAUSE, S_PLAY, S_OVER} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               p1_prev, p2_prev;
  logic [7:0]         p1_q, p2_q;
  logic               side_q, serve_q;
  logic [1:0]         winner_q;

  logic               ev1, ev2, pause_done;
  logic [7:0]         p1_inc, p2_inc;
  logic signed [8:0]  lead1, lead2;
  logic               p1_win, p2_win;

  assign ev1        = sk.p1_point & ~p1_prev;
  assign ev2        = sk.p2_point & ~p2_prev;
  assign pause_done = (cnt == CNT_LAST);
  assign p1_inc     = (p1_q >= MAX_S) ? MAX_S : p1_q + 8'd1;
  assign p2_inc     = (p2_q >= MAX_S) ? MAX_S : p2_q + 8'd1;
  // Lead measured on the post-point score against the opponent's unchanged score.
  assign lead1      = $signed({1'b0, p1_inc}) - $signed({1'b0, p2_q});
  assign lead2      = $signed({1'b0, p2_inc}) - $signed({1'b0, p1_q});
  assign p1_win     = ((p1_inc >= WIN_S) && (lead1 >= 9'sd2)) || (p1_inc == MAX_S);
  assign p2_win     = ((p2_inc >= WIN_S) && (lead2 >= 9'sd2)) || (p2_inc == MAX_S);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_PAUSE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (sk.new_game) state_nxt = S_PAUSE;
    else begin
      case (state)
        S_PAUSE: if (pause_done) state_nxt = S_PLAY;
        S_PLAY: begin
          if (ev1 && ev2)  state_nxt = S_PAUSE;
          else if (ev1)    state_nxt = p1_win ? S_OVER : S_PAUSE;
          else if (ev2)    state_nxt = p2_win ? S_OVER : S_PAUSE;
        end
        S_OVER:  state_nxt = S_OVER;
        default: state_nxt = S_PAUSE;
      endcase
    end
  end

  always_comb begin
    sk.frozen    = (state != S_PLAY);
    sk.game_over = (state == S_OVER);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt      <= '0;
      p1_prev  <= 1'b0;
      p2_prev  <= 1'b0;
      p1_q     <= '0;
      p2_q     <= '0;
      side_q   <= 1'b0;
      serve_q  <= 1'b0;
      winner_q <= 2'b00;
    end else begin
      // Edge history tracks every cycle so a level held through a pause never scores.
      p1_prev <= sk.p1_point;
      p2_prev <= sk.p2_point;
      serve_q <= 1'b0;
      if (sk.new_game) begin
        cnt      <= '0;
        p1_q     <= '0;
        p2_q     <= '0;
        side_q   <= 1'b0;
        winner_q <= 2'b00;
      end else begin
        case (state)
          S_PAUSE: begin
            if (pause_done) begin
              cnt     <= '0;
              serve_q <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          S_PLAY: begin
            cnt <= '0;
            if (ev1 && !ev2) begin
              p1_q   <= p1_inc;
              side_q <= 1'b1;
              if (p1_win) winner_q <= 2'b01;
            end else if (ev2 && !ev1) begin
              p2_q   <= p2_inc;
              side_q <= 1'b0;
              if (p2_win) winner_q <= 2'b10;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sk.p1_score   = p1_q;
  assign sk.p2_score   = p2_q;
  assign sk.serve      = serve_q;
  assign sk.serve_side = side_q;
  assign sk.winner     = winner_q;
endmodule
